periodic_framer_multi: RTL

- Trigger-driven OFDM symbol framer for the RFNoC sync chain, placed between the Schmidl-Cox detector output and the FFT input.
- On a trigger-flagged input sample it does the following, in order:
  - skips a programmable offset;
  - emits up to max_frames frames of frame_len samples, each with tlast on its last sample;
  - discards gap_len samples (the cyclic prefix) between frames.
- Generalises the fixed periodic framer with the following:
  - parametrised widths;
  - unlimited-frame mode;
  - retrigger handling;
  - shadowed settings;
  - status outputs.

---
 rtl/periodic_framer_multi.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/periodic_framer_multi.sv
// Trigger-driven OFDM symbol framer: skips an offset after a trigger, then cuts
// frame_len-sample frames separated by gap_len discarded samples (cyclic prefix).
module periodic_framer_multi #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned LEN_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned SR_BASE   = 16
) (
    input  logic                 ce_clk,
    input  logic                 ce_rst_n,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    input  logic [WIDTH-1:0]     i_tdata,
    input  logic                 i_tuser,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [WIDTH-1:0]     o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic [CNT_WIDTH-1:0] o_frame_idx,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_trig_dropped
);

    typedef enum logic [1:0] {StIdle, StOffset, StFrame, StGap} state_e;

    localparam logic [7:0] AddrFrameLen = 8'(SR_BASE);
    localparam logic [7:0] AddrGapLen   = 8'(SR_BASE + 1);
    localparam logic [7:0] AddrOffset   = 8'(SR_BASE + 2);
    localparam logic [7:0] AddrMaxFrm   = 8'(SR_BASE + 3);
    localparam logic [7:0] AddrMode     = 8'(SR_BASE + 4);

    localparam logic [LEN_WIDTH-1:0] LenOne = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    // Live settings
    logic [LEN_WIDTH-1:0] frame_len_q, gap_len_q, offset_q;
    logic [CNT_WIDTH-1:0] max_frames_q;
    logic [1:0]           mode_q;

    // Sequence state and shadows
    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] frame_idx_q, frame_idx_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q;
    logic [LEN_WIDTH-1:0] sh_len_q, sh_gap_q;
    logic [CNT_WIDTH-1:0] sh_max_q;
    logic                 sh_retrig_q;
    logic                 pend_q, pend_d;
    logic [LEN_WIDTH-1:0] pend_el_q, pend_el_d;
    logic                 load_shadow;
    logic                 drop_inc;

    logic                 unused_set_data;
    assign unused_set_data = ^set_data;

    // Settings registers, reset to the documented defaults
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            frame_len_q  <= LEN_WIDTH'(64);
            gap_len_q    <= LEN_WIDTH'(16);
            offset_q     <= '0;
            max_frames_q <= CntOne;
            mode_q       <= '0;
        end else if (set_stb) begin
            case (set_addr)
                AddrFrameLen: frame_len_q  <= set_data[LEN_WIDTH-1:0];
                AddrGapLen:   gap_len_q    <= set_data[LEN_WIDTH-1:0];
                AddrOffset:   offset_q     <= set_data[LEN_WIDTH-1:0];
                AddrMaxFrm:   max_frames_q <= set_data[CNT_WIDTH-1:0];
                AddrMode:     mode_q       <= set_data[1:0];
                default:      ;
            endcase
        end
    end

    // A zero-offset trigger makes its own beat frame sample 0, so the handshake and
    // counters switch to frame behaviour combinationally for that beat.
    logic zero_start, framing, pass_mode, in_beat, last_pos, restart;
    logic [LEN_WIDTH-1:0] eff_cnt, eff_len, eff_gap, el_inc, elapsed;
    logic [CNT_WIDTH-1:0] eff_idx, eff_max, idx_next;

    assign zero_start = i_tvalid && i_tuser && (state_q != StFrame) &&
                        (frame_len_q != '0) && (offset_q == '0);
    assign framing    = (state_q == StFrame) || zero_start;
    assign pass_mode  = framing || ((state_q == StIdle) && !mode_q[1]);

    assign i_tready = pass_mode ? o_tready : 1'b1;
    assign o_tvalid = pass_mode ? i_tvalid : 1'b0;
    assign o_tdata  = i_tdata;
    assign in_beat  = i_tvalid && i_tready;

    assign eff_cnt  = zero_start ? '0 : cnt_q;
    assign eff_len  = zero_start ? frame_len_q : sh_len_q;
    assign eff_gap  = zero_start ? gap_len_q : sh_gap_q;
    assign eff_max  = zero_start ? max_frames_q : sh_max_q;
    assign eff_idx  = zero_start ? '0 : frame_idx_q;
    assign idx_next = eff_idx + CntOne;
    assign last_pos = framing && (eff_cnt == eff_len - LenOne);

    // Beats since a pending retrigger, including the current one
    assign el_inc   = (pend_el_q == '1) ? pend_el_q : pend_el_q + LenOne;
    assign elapsed  = pend_q ? el_inc : LenOne;
    assign restart  = (state_q == StFrame) && sh_retrig_q && (pend_q || i_tuser);

    assign o_tlast        = last_pos;
    assign o_frame_idx    = eff_idx;
    assign o_busy         = (state_q != StIdle);
    assign o_trig_dropped = drop_cnt_q;

    // Next-state: trigger acceptance, offset/gap countdown, frame counting, retrigger
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_idx_d = frame_idx_q;
        pend_d      = pend_q;
        pend_el_d   = pend_el_q;
        load_shadow = 1'b0;
        drop_inc    = 1'b0;

        if (in_beat && (state_q != StFrame)) begin
            if (i_tuser && (frame_len_q != '0)) begin
                load_shadow = 1'b1;
                frame_idx_d = '0;
                pend_d      = 1'b0;
                // offset 0 is finished by the framing branch below
                if (offset_q == LenOne) begin
                    state_d = StFrame;
                    cnt_d   = '0;
                end else if (offset_q != '0) begin
                    state_d = StOffset;
                    cnt_d   = offset_q - LenOne;
                end
            end else begin
                drop_inc = i_tuser;
                if ((state_q == StOffset) || (state_q == StGap)) begin
                    if (cnt_q == LenOne) begin
                        state_d = StFrame;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - LenOne;
                    end
                end
            end
        end

        if (in_beat && framing) begin
            if (last_pos) begin
                if ((state_q == StFrame) && i_tuser && (!sh_retrig_q || pend_q)) begin
                    drop_inc = 1'b1;
                end
                if (restart) begin
                    pend_d    = 1'b0;
                    pend_el_d = '0;
                    if (frame_len_q == '0) begin
                        drop_inc = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        load_shadow = 1'b1;
                        frame_idx_d = '0;
                        if (offset_q > elapsed) begin
                            state_d = StOffset;
                            cnt_d   = offset_q - elapsed;
                        end else begin
                            state_d = StFrame;
                            cnt_d   = '0;
                        end
                    end
                end else if ((eff_max != '0) && (idx_next == eff_max)) begin
                    state_d     = StIdle;
                    frame_idx_d = idx_next;
                end else if (eff_gap == '0) begin
                    state_d     = StFrame;
                    cnt_d       = '0;
                    frame_idx_d = idx_next;
                end else begin
                    state_d     = StGap;
                    cnt_d       = eff_gap;
                    frame_idx_d = idx_next;
                end
            end else begin
                state_d = StFrame;
                cnt_d   = eff_cnt + LenOne;
                if (pend_q) begin
                    pend_el_d = el_inc;
                end
                if ((state_q == StFrame) && i_tuser) begin
                    if (sh_retrig_q && !pend_q) begin
                        pend_d    = 1'b1;
                        pend_el_d = LenOne;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
        end
    end

    // Sequence state, shadows and status counters
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            frame_idx_q <= '0;
            drop_cnt_q  <= '0;
            sh_len_q    <= '0;
            sh_gap_q    <= '0;
            sh_max_q    <= '0;
            sh_retrig_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_el_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_idx_q <= frame_idx_d;
            pend_q      <= pend_d;
            pend_el_q   <= pend_el_d;
            if (drop_inc && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + CntOne;
            end
            if (load_shadow) begin
                sh_len_q    <= frame_len_q;
                sh_gap_q    <= gap_len_q;
                sh_max_q    <= max_frames_q;
                sh_retrig_q <= mode_q[0];
            end
        end
    end

endmodule
